axi_rd_arbiter: RTL and testbench

Shares the single AXI read port between the instruction cache (requester 0) and the data cache (requester 1). Round-robin grant with one outstanding transaction; the grant is held from the AR handshake through the last R beat. Sits between both cache miss engines and the top-level m_axi read channel.

---
 rtl/axi_rd_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between icache (0) and dcache (1).
// Define AXI_RD_ARB_PERF_EN to add per-requester grant and wait counters.
module axi_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          s_arvalid,
    input  logic [2*ADDR_W-1:0] s_araddr,
    input  logic [15:0]         s_arlen,
    input  logic [5:0]          s_arsize,
    input  logic [3:0]          s_arburst,
    output logic [1:0]          s_arready,
    output logic [1:0]          s_rvalid,
    output logic [1:0]          s_rlast,
    output logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rready,
    output logic                m_axi_arvalid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    input  logic                m_axi_arready,
    input  logic                m_axi_rvalid,
    input  logic                m_axi_rlast,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    output logic                m_axi_rready,
    output logic                grant_id
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [63:0]         perf_grants,
    output logic [63:0]         perf_wait
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;

    logic              w_winner;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_len;
    logic [2:0]        w_sel_size;
    logic [1:0]        w_sel_burst;
    logic              w_ar_hs;
    logic              w_in_data;
    logic              w_rready;
    logic              w_r_done;

    // A tie goes to whoever did not own the bus last.
    always_comb begin
        w_winner    = (s_arvalid == 2'b11) ? ~r_last_grant : s_arvalid[1];
        w_sel_addr  = w_winner ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
        w_sel_len   = w_winner ? s_arlen[15:8]   : s_arlen[7:0];
        w_sel_size  = w_winner ? s_arsize[5:3]   : s_arsize[2:0];
        w_sel_burst = w_winner ? s_arburst[3:2]  : s_arburst[1:0];
    end

    assign w_ar_hs   = (r_state == S_ADDR) && m_axi_arready;
    assign w_in_data = (r_state == S_DATA);
    assign w_rready  = w_in_data && s_rready[r_grant];
    assign w_r_done  = w_in_data && m_axi_rvalid && w_rready && m_axi_rlast;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|s_arvalid) begin
                        r_grant   <= w_winner;
                        r_araddr  <= w_sel_addr;
                        r_arlen   <= w_sel_len;
                        r_arsize  <= w_sel_size;
                        r_arburst <= w_sel_burst;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_r_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        s_arready[0] = w_ar_hs && !r_grant;
        s_arready[1] = w_ar_hs &&  r_grant;
        s_rvalid[0]  = w_in_data && m_axi_rvalid && !r_grant;
        s_rvalid[1]  = w_in_data && m_axi_rvalid &&  r_grant;
        s_rlast[0]   = w_in_data && m_axi_rlast  && !r_grant;
        s_rlast[1]   = w_in_data && m_axi_rlast  &&  r_grant;
        s_rdata      = w_in_data ? m_axi_rdata : '0;
    end

    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = r_arsize;
    assign m_axi_arburst = r_arburst;
    assign m_axi_rready  = w_rready;
    assign grant_id      = r_grant;

`ifdef AXI_RD_ARB_PERF_EN
    logic [1:0][31:0] r_perf_grants;
    logic [1:0][31:0] r_perf_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_grants <= '0;
            r_perf_wait   <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (s_arready[i])
                    r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
                if (s_arvalid[i] && !s_arready[i])
                    r_perf_wait[i] <= r_perf_wait[i] + 32'd1;
            end
        end
    end

    assign perf_grants = r_perf_grants;
    assign perf_wait   = r_perf_wait;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed vector table, hand sequences,
// and randomized transactions against a transaction-level round-robin model.
module tb_axi_rd_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          s_arvalid;
    logic [2*ADDR_W-1:0] s_araddr;
    logic [15:0]         s_arlen;
    logic [5:0]          s_arsize;
    logic [3:0]          s_arburst;
    logic [1:0]          s_arready;
    logic [1:0]          s_rvalid;
    logic [1:0]          s_rlast;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rready;
    logic                m_axi_arvalid;
    logic [ADDR_W-1:0]   m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic                m_axi_arready;
    logic                m_axi_rvalid;
    logic                m_axi_rlast;
    logic [DATA_W-1:0]   m_axi_rdata;
    logic                m_axi_rready;
    logic                grant_id;
`ifdef AXI_RD_ARB_PERF_EN
    logic [63:0]         perf_grants;
    logic [63:0]         perf_wait;
`endif

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rdata(s_rdata), .s_rready(s_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
        .m_axi_rdata(m_axi_rdata), .m_axi_rready(m_axi_rready),
        .grant_id(grant_id)
`ifdef AXI_RD_ARB_PERF_EN
        , .perf_grants(perf_grants), .perf_wait(perf_wait)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: who owned the bus last, plus per-requester request fields.
    logic              m_last;
    logic [ADDR_W-1:0] ad [2];
    logic [7:0]        ln [2];
    logic [2:0]        sz [2];
    logic [1:0]        bu [2];

    typedef struct {
        logic [1:0] req;
        logic       exp_g;
        logic [7:0] len;
        int         ar_delay;
        int         stall_at;
        int         stall_n;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] outs();
        return {s_arready, s_rvalid, s_rlast, s_rdata, m_axi_arvalid, m_axi_araddr,
                m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready, grant_id};
    endfunction

    // Runs one full transaction from the IDLE cycle; the slave side is modelled inline.
    task automatic do_txn(input logic [1:0] req, input logic exp_g, input int ar_delay,
                          input int stall_at, input int stall_n, input int rst_beat);
        int beats, cyc, stalled;
        logic own_rdy, last_b;
        logic [DATA_W-1:0] d;
        logic [1:0] one_hot;
        one_hot   = exp_g ? 2'b10 : 2'b01;
        s_arvalid = req;
        s_araddr  = {ad[1], ad[0]};
        s_arlen   = {ln[1], ln[0]};
        s_arsize  = {sz[1], sz[0]};
        s_arburst = {bu[1], bu[0]};
        s_rready  = 2'b11;
        #3;
        chk("ar_not_early", {s_arready, m_axi_arvalid}, '0);
        tick();
        chk("ar_latency", m_axi_arvalid, 1'b1);
        chk("grant_id", grant_id, exp_g);
        for (int k = 0; k < ar_delay; k++) begin
            m_axi_arready = 1'b0;
            #3;
            chk("ar_hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, s_arready},
                {1'b1, ad[exp_g], ln[exp_g], sz[exp_g], bu[exp_g], 2'b00});
            tick();
        end
        m_axi_arready = 1'b1;
        #3;
        chk("ar_handshake", {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, s_arready},
            {1'b1, ad[exp_g], ln[exp_g], sz[exp_g], bu[exp_g], one_hot});
        tick();
        m_axi_arready    = 1'b0;
        s_arvalid[exp_g] = 1'b0;
        beats = 0; cyc = 0; stalled = 0;
        d = {$urandom, $urandom};
        while (beats <= int'(ln[exp_g]) && cyc < 600) begin
            own_rdy = !(beats == stall_at && stalled < stall_n);
            if (!own_rdy) stalled++;
            last_b = (beats == int'(ln[exp_g]));
            s_rready[exp_g]  = own_rdy;
            s_rready[~exp_g] = 1'($urandom_range(0, 1));
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rlast  = last_b;
            #3;
            if (rst_beat == beats) begin
                reset = 1'b0;
                #1;
                chk("async_reset", outs(), '0);
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                s_arvalid    = 2'b00;
                tick();
                reset  = 1'b1;
                m_last = 1'b1;
                return;
            end
            chk("r_route", {s_arready, s_rvalid, s_rlast, m_axi_rready},
                {2'b00, one_hot, last_b ? one_hot : 2'b00, own_rdy});
            chk("r_data", s_rdata, d);
            if (own_rdy) begin
                beats++;
                d = {$urandom, $urandom};
            end
            tick();
            cyc++;
        end
        chk("beat_count", beats, int'(ln[exp_g]) + 1);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        s_rready     = 2'b11;
        #3;
        chk("idle_ignores_r", {s_rvalid, s_rlast, m_axi_rready, m_axi_arvalid}, '0);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_last = exp_g;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'b11, 1'b1, 8'd3, 0, -1, 0};
        vt[1] = '{2'b11, 1'b0, 8'd1, 0, -1, 0};
        vt[2] = '{2'b11, 1'b1, 8'd0, 0, -1, 0};
        vt[3] = '{2'b11, 1'b0, 8'd2, 0, -1, 0};
        vt[4] = '{2'b10, 1'b1, 8'd7, 5,  3, 3};
        vt[5] = '{2'b10, 1'b1, 8'd0, 1, -1, 0};
        vt[6] = '{2'b11, 1'b0, 8'd1, 0, -1, 0};
        vt[7] = '{2'b01, 1'b0, 8'd0, 0, -1, 0};
        vt[8] = '{2'b11, 1'b1, 8'd3, 2,  1, 2};
        vt[9] = '{2'b01, 1'b0, 8'd4, 0,  2, 3};

        reset = 1'b0;
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready = '0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0;
        sz[0] = 3'd3; sz[1] = 3'd2; bu[0] = 2'd1; bu[1] = 2'd2;
        #3;
        chk("reset_outputs", outs(), '0);
        #20;
        tick();
        reset  = 1'b1;
        m_last = 1'b1;
        tick();

        // Simultaneous requests right after reset: icache first, then pending dcache.
        ad[0] = 64'h2000; ad[1] = 64'h8000; ln[0] = 8'd3; ln[1] = 8'd3;
        do_txn(2'b11, 1'b0, 0, -1, 0, -1);
        do_txn(2'b10, 1'b1, 0, -1, 0, -1);

        // icache alone, 8-beat burst.
        ad[0] = 64'h1000; ln[0] = 8'd7;
        do_txn(2'b01, 1'b0, 0, -1, 0, -1);

        for (int i = 0; i < 10; i++) begin
            ad[0] = 64'h10000 + 64'(i) * 64'h40;
            ad[1] = 64'h90000 + 64'(i) * 64'h80;
            ln[0] = vt[i].len; ln[1] = vt[i].len;
            do_txn(vt[i].req, vt[i].exp_g, vt[i].ar_delay, vt[i].stall_at, vt[i].stall_n, -1);
        end

        // Reset during beat 3 of 8, then a fresh dcache request.
        ad[0] = 64'h3000; ln[0] = 8'd7;
        do_txn(2'b01, 1'b0, 0, -1, 0, 3);
        tick();
        ad[1] = 64'hA000; ln[1] = 8'd2;
        do_txn(2'b10, 1'b1, 0, -1, 0, -1);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] req;
            logic       eg;
            int         len_r;
            req = 2'($urandom_range(1, 3));
            eg  = (req == 2'b11) ? ~m_last : req[1];
            for (int r = 0; r < 2; r++) begin
                ad[r] = {$urandom, $urandom};
                ln[r] = 8'($urandom_range(0, 3));
                sz[r] = 3'($urandom_range(0, 7));
                bu[r] = 2'($urandom_range(0, 3));
            end
            len_r = int'(ln[eg]);
            do_txn(req, eg, int'($urandom_range(0, 3)), int'($urandom_range(0, len_r)),
                   int'($urandom_range(0, 2)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
